muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/HI/LO width; SHALL be even and >= 8.
REQ-002 Parameter CNT_W, default 6, iteration counter width; SHALL satisfy 2**CNT_W > WIDTH.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request strobe; sampled only when busy=0.
REQ-006 funct  in  6  operation, MIPS funct encoding: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13.
REQ-007 a  in  WIDTH  operand A (multiplicand / dividend / MTHI-MTLO data).
REQ-008 b  in  WIDTH  operand B (multiplier / divisor).
REQ-009 abort  in  1  flushes an in-flight MULT/DIV.
REQ-010 busy  out  1  high while a MULT/DIV is in flight.
REQ-011 done  out  1  one-cycle pulse when HI/LO receive a MULT/DIV result.
REQ-012 hi  out  WIDTH  HI register.
REQ-013 lo  out  WIDTH  LO register.
REQ-014 div0  out  1  sticky flag: last completed DIV/DIVU had b=0.

Function
REQ-015 FSM states IDLE, CALC, FIX; IDLE->CALC on start with a MULT/DIV funct; CALC->FIX after WIDTH iterations; FIX->IDLE unconditionally.
REQ-016 Accepted start latches a, b, funct into internal registers; inputs may change afterwards without effect.
REQ-017 MTHI/MTLO with start=1 in IDLE SHALL write hi (or lo) from a at that edge; no busy, no done; other register unchanged.
REQ-018 start with unlisted funct SHALL be ignored; hi, lo, div0 unchanged.
REQ-019 start while busy=1 SHALL be ignored, including MTHI/MTLO.
REQ-020 Latency: start accepted at edge E0; busy=1 from E0 through E(WIDTH+1); hi/lo written and done=1 at E(WIDTH+1); busy=0 after E(WIDTH+1); new start accepted in the cycle after done.
REQ-021 Multiply: radix-2 shift-add on magnitudes, 2*WIDTH-bit product; {hi,lo} = full product; MULT signed, MULTU unsigned.
REQ-022 Divide: restoring, one quotient bit per CALC cycle on magnitudes; lo=quotient, hi=remainder.
REQ-023 Signed divide truncates toward zero; remainder sign follows dividend; sign fix-up applied in FIX.
REQ-024 Signed overflow (a = most negative, b = -1): lo = most negative, hi = 0, div0 = 0.
REQ-025 Divide by zero: lo = all ones, hi = a (unmodified), div0 = 1; still takes full latency.
REQ-026 div0 cleared by next completed DIV/DIVU with b!=0; MULT/MTHI/MTLO leave it unchanged.
REQ-027 abort in CALC or FIX returns to IDLE next edge; hi, lo, div0 unchanged; no done; abort in IDLE has no effect.
REQ-028 abort and start in the same IDLE cycle: start wins.
REQ-029 hi and lo SHALL hold value in every cycle not covered by REQ-017 or REQ-020.

Reset
REQ-030 rst_n low asynchronously forces IDLE, busy=0, done=0, div0=0, hi=0, lo=0, counter=0.
REQ-031 Reset during CALC/FIX discards the operation; no done after release.
REQ-032 First start is sampled at the first rising edge with rst_n high.

Structure
REQ-033 Package muldiv_pkg SHALL hold funct encodings, FSM state typedef, and the divide-by-zero quotient constant.
REQ-034 One sub-module muldiv_step: combinational single iteration (add-or-pass / subtract-and-compare) selected by a mul/div flag; muldiv_unit owns FSM, counter, operand and HI/LO registers.
REQ-035 No combinational path from inputs to busy, done, hi, lo, div0.

Verification (WIDTH=32)
REQ-036 MULT a=0xFFFFFFFE(-2), b=3 -> done at E33, hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-037 DIV a=-7, b=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1); DIVU a=7, b=2 -> lo=3, hi=1.
REQ-038 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5, div0=1; next DIVU 9/3 -> div0=0.
REQ-039 MTHI a=0x12345678 in IDLE -> hi updated next edge, lo unchanged; MTLO during busy -> ignored, lo unchanged.
REQ-040 MULT started, abort at E10 -> IDLE at E11, no done, hi/lo keep prior values; rst_n low at E5 of DIV -> all outputs 0 immediately, no done after release.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
// Holds the MIPS funct codes, the FSM state type and the divide-by-zero quotient.
package muldiv_pkg;

    typedef enum logic [5:0] {
        F_MTHI  = 6'h11,
        F_MTLO  = 6'h13,
        F_MULT  = 6'h18,
        F_MULTU = 6'h19,
        F_DIV   = 6'h1A,
        F_DIVU  = 6'h1B
    } funct_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    // All-ones quotient for a zero divisor, sliced down to the unit width (WIDTH <= 64).
    localparam int                   MAX_WIDTH = 64;
    localparam logic [MAX_WIDTH-1:0] DIV0_QUOT = '1;

    function automatic logic is_muldiv(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [5:0] f);
        return (f == F_MULT) || (f == F_DIV);
    endfunction

    function automatic logic is_div_op(input logic [5:0] f);
        return (f == F_DIV) || (f == F_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the datapath: shift-add for multiply,
// shift-subtract-compare (restoring) for divide, both on magnitudes.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             mode_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mq,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] mq_nxt
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] sub;
    logic             ge;

    // NOTE: every output of this block is assigned on every path, so no latch can be inferred.
    always_comb begin
        sum     = {1'b0, acc} + (mq[0] ? {1'b0, opb} : '0);
        shifted = {acc, mq[WIDTH-1]};
        ge      = (shifted >= {1'b0, opb});
        // When ge holds the difference is below opb, so the truncated subtract is exact.
        sub     = shifted[WIDTH-1:0] - opb;
        if (mode_div) begin
            acc_nxt = ge ? sub : shifted[WIDTH-1:0];
            mq_nxt  = {mq[WIDTH-2:0], ge};
        end else begin
            acc_nxt = sum[WIDTH:1];
            mq_nxt  = {sum[0], mq[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: WIDTH CALC cycles on
// magnitudes followed by one FIX cycle for sign correction and commit.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               op_div_q;
    logic               neg_quot_q;
    logic               neg_rem_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   bmag_q;
    logic [WIDTH-1:0]   acc_q, mq_q;
    logic [WIDTH-1:0]   acc_nxt, mq_nxt;

    logic               accept, wr_hi, wr_lo, step_en, commit;
    logic               sgn, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // ---------------- FSM ----------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start && is_muldiv(funct)) state_d = CALC;
            CALC: begin
                if (abort)                   state_d = IDLE;
                else if (cnt_q == LAST_ITER) state_d = FIX;
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        accept  = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        step_en = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                accept = start && is_muldiv(funct);
                wr_hi  = start && (funct == F_MTHI);
                wr_lo  = start && (funct == F_MTLO);
            end
            CALC:    step_en = !abort;
            FIX:     commit  = !abort;
            default: ;
        endcase
    end

    // ---------------- Operand capture and iteration ----------------
    assign sgn   = is_signed_op(funct);
    assign a_neg = sgn & a[WIDTH-1];
    assign b_neg = sgn & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode_div (op_div_q),
        .acc      (acc_q),
        .mq       (mq_q),
        .opb      (bmag_q),
        .acc_nxt  (acc_nxt),
        .mq_nxt   (mq_nxt)
    );

    // NOTE: datapath registers are reset too, so no X can ever reach hi/lo through the FIX mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            op_div_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            a_q        <= '0;
            bmag_q     <= '0;
            acc_q      <= '0;
            mq_q       <= '0;
        end else if (accept) begin
            cnt_q      <= '0;
            op_div_q   <= is_div_op(funct);
            neg_quot_q <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            a_q        <= a;
            bmag_q     <= b_mag;
            acc_q      <= '0;
            mq_q       <= a_mag;
        end else if (step_en) begin
            cnt_q      <= cnt_q + 1'b1;
            acc_q      <= acc_nxt;
            mq_q       <= mq_nxt;
        end
    end

    // ---------------- Sign fix-up and HI/LO commit ----------------
    always_comb begin
        prod     = {acc_q, mq_q};
        prod_fix = neg_quot_q ? -prod : prod;
        b_zero   = (bmag_q == '0);
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (op_div_q) begin
            // Zero divisor hands back the raw dividend, not its magnitude.
            if (b_zero) begin
                res_lo = DIV0_QUOT[WIDTH-1:0];
                res_hi = a_q;
            end else begin
                res_lo = neg_quot_q ? -mq_q : mq_q;
                res_hi = neg_rem_q ? -acc_q : acc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            div0 <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= commit;
            if (commit) begin
                hi <= res_hi;
                lo <= res_lo;
                if (op_div_q) div0 <= b_zero;
            end else begin
                if (wr_hi) hi <= a;
                if (wr_lo) lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// operations compared against a plain-arithmetic HI/LO reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a, b;
    logic             abort;
    logic             busy, done, div0;
    logic [WIDTH-1:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_hi, exp_lo;
    logic        exp_div0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .funct (funct),
        .a     (a),
        .b     (b),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .div0  (div0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: architectural HI/LO results straight from integer arithmetic.
    task automatic model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (f)
            F_MULT: begin
                p = 64'(sx * sy);
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            F_MULTU: begin
                p = {32'd0, x} * {32'd0, y};
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            F_DIV, F_DIVU: begin
                if (y == 32'd0) begin
                    exp_lo   = 32'hFFFF_FFFF;
                    exp_hi   = x;
                    exp_div0 = 1'b1;
                end else if (f == F_DIV) begin
                    q = sx / sy;
                    r = sx % sy;
                    exp_lo   = q[31:0];
                    exp_hi   = r[31:0];
                    exp_div0 = 1'b0;
                end else begin
                    exp_lo   = x / y;
                    exp_hi   = x % y;
                    exp_div0 = 1'b0;
                end
            end
            default: ;
        endcase
    endtask

    // Starts one MULT/DIV at the next edge and checks latency and results.
    task automatic run_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y,
                          input string tag, input bit mtlo_mid, input bit abort_on_start);
        logic [31:0] prev_lo;
        int          k;
        bit          seen;
        prev_lo = exp_lo;
        model(f, x, y);
        start = 1'b1; funct = f; a = x; b = y; abort = abort_on_start;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        a = $urandom; b = $urandom; funct = 6'($urandom);
        check($sformatf("%s.busy_e0", tag), busy, 1);
        seen = 0;
        k    = 0;
        for (int i = 1; i <= WIDTH + 8 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                k    = i;
            end
            if (mtlo_mid && i == 5) begin
                start = 1'b1; funct = F_MTLO; a = $urandom;
            end
            if (mtlo_mid && i == 6) begin
                start = 1'b0;
                check($sformatf("%s.mtlo_busy_ignored", tag), lo, prev_lo);
            end
        end
        check($sformatf("%s.latency", tag), 64'(k), 64'(WIDTH + 1));
        check($sformatf("%s.busy_done", tag), busy, 0);
        check($sformatf("%s.hi", tag), hi, exp_hi);
        check($sformatf("%s.lo", tag), lo, exp_lo);
        check($sformatf("%s.div0", tag), div0, exp_div0);
    endtask

    // Starts a MULT, raises abort after edge n so it is sampled at edge n+1.
    task automatic abort_test(input int n, input string tag);
        bit seen;
        start = 1'b1; funct = F_MULT; a = $urandom; b = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (n) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check($sformatf("%s.idle", tag), busy, 0);
        seen = 0;
        repeat (WIDTH + 4) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check($sformatf("%s.no_done", tag), 64'(seen), 0);
        check($sformatf("%s.hi", tag), hi, exp_hi);
        check($sformatf("%s.lo", tag), lo, exp_lo);
        check($sformatf("%s.div0", tag), div0, exp_div0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen;
        logic [5:0]  rf;
        logic [31:0] ra, rb;

        rst_n = 1'b1; start = 1'b0; funct = '0; a = '0; b = '0; abort = 1'b0;
        exp_hi = '0; exp_lo = '0; exp_div0 = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.hi", hi, 0);
        check("reset.lo", lo, 0);
        check("reset.div0", div0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(F_MULT,  32'hFFFF_FFFE, 32'd3, "mult_neg2x3", 0, 0);
        @(negedge clk);
        check("done_pulse", done, 0);
        run_op(F_MULTU, 32'hFFFF_FFFE, 32'd3, "multu_big", 0, 0);
        run_op(F_DIV,   32'hFFFF_FFF9, 32'd2, "div_neg7_2", 0, 0);
        run_op(F_DIVU,  32'd7, 32'd2, "divu_7_2", 0, 0);
        run_op(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 0, 0);
        run_op(F_DIVU,  32'd5, 32'd0, "divu_by0", 0, 0);
        run_op(F_MULT,  32'd6, 32'd7, "mult_keeps_div0", 0, 0);
        run_op(F_DIVU,  32'd9, 32'd3, "divu_clear", 0, 0);
        run_op(F_DIV,   32'hFFFF_FF00, 32'd0, "div_neg_by0", 0, 0);

        start = 1'b1; funct = F_MTHI; a = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        exp_hi = 32'h1234_5678;
        check("mthi.hi", hi, exp_hi);
        check("mthi.lo", lo, exp_lo);
        check("mthi.busy", busy, 0);
        check("mthi.done", done, 0);
        check("mthi.div0", div0, exp_div0);

        start = 1'b1; funct = F_MTLO; a = 32'hCAFE_F00D;
        @(negedge clk);
        start = 1'b0;
        exp_lo = 32'hCAFE_F00D;
        check("mtlo.lo", lo, exp_lo);
        check("mtlo.hi", hi, exp_hi);

        run_op(F_MULTU, $urandom, $urandom, "mtlo_during_busy", 1, 0);

        start = 1'b1; funct = 6'h20; a = $urandom; b = $urandom;
        @(negedge clk);
        start = 1'b0;
        check("bad_funct.busy", busy, 0);
        check("bad_funct.hi", hi, exp_hi);
        check("bad_funct.lo", lo, exp_lo);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort.busy", busy, 0);
        check("idle_abort.lo", lo, exp_lo);

        abort_test(10, "abort_calc");
        abort_test(WIDTH, "abort_fix");
        run_op(F_DIV, $urandom, $urandom_range(1, 1000), "start_beats_abort", 0, 1);

        run_op(F_DIVU, 32'd11, 32'd0, "pre_reset_div0", 0, 0);
        start = 1'b1; funct = F_DIV; a = $urandom; b = $urandom | 32'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_hi = '0; exp_lo = '0; exp_div0 = 1'b0;
        check("midreset.busy", busy, 0);
        check("midreset.done", done, 0);
        check("midreset.hi", hi, 0);
        check("midreset.lo", lo, 0);
        check("midreset.div0", div0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (WIDTH + 4) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("midreset.no_done", 64'(seen), 0);
        check("midreset.lo_hold", lo, 0);
        run_op(F_MULT, 32'h8000_0000, 32'h8000_0000, "after_reset", 0, 0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       rf = F_MULT;
                1:       rf = F_MULTU;
                2:       rf = F_DIV;
                default: rf = F_DIVU;
            endcase
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            run_op(rf, ra, rb, $sformatf("rand%0d", n), 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
